// File: rtl/button_pkg.sv
// Shared definitions for the button reader: event encodings and field widths.
package button_pkg;

   localparam int unsigned EVT_W = 5;
   localparam int unsigned CH_W  = 3;

   // Event type field, upper two bits of an event word
   typedef enum logic [1:0] {
      EvtPress   = 2'b00,
      EvtRelease = 2'b01,
      EvtLong    = 2'b10,
      EvtRsvd    = 2'b11
   } evt_type_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, debounce counter, edge pulses and
// optional long-press detection (enabled by defining BTN_LONG_PRESS_EN).
module btn_debounce_ch
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned LONG_CYCLES     = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic state,
   output logic press_pulse,
   output logic rel_pulse,
   output logic long_pulse
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

   logic            sync_q1;
   logic            sync_q2;
   logic [DB_W-1:0] db_cnt_q;
   logic            state_q;
   logic            press_q;
   logic            rel_q;
   logic            toggle;

   // The debounced level flips on the last of DEBOUNCE_CYCLES differing samples
   assign toggle = (sync_q2 != state_q) && (db_cnt_q == DB_LAST);

   // Synchronize, count disagreeing samples, flip the level and emit edge pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1  <= 1'b0;
         sync_q2  <= 1'b0;
         db_cnt_q <= '0;
         state_q  <= 1'b0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
         if ((sync_q2 == state_q) || toggle) begin
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + DB_ONE;
         end
         if (toggle) begin
            state_q <= ~state_q;
         end
         press_q <= toggle && !state_q;
         rel_q   <= toggle && state_q;
      end
   end

   assign state       = state_q;
   assign press_pulse = press_q;
   assign rel_pulse   = rel_q;

`ifdef BTN_LONG_PRESS_EN
   localparam int unsigned LG_W = $clog2(LONG_CYCLES + 1);
   localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);
   localparam logic [LG_W-1:0] LG_DONE = LG_W'(LONG_CYCLES);
   localparam logic [LG_W-1:0] LG_ONE  = LG_W'(1);

   logic [LG_W-1:0] long_cnt_q;
   logic            long_q;

   // Count pressed cycles; fire once, then park at LG_DONE until release.
   // A cycle that flips the level never fires, so long and release cannot coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         long_cnt_q <= '0;
         long_q     <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if (!state_q || toggle) begin
            long_cnt_q <= '0;
         end else if (long_cnt_q == LG_LAST) begin
            long_q     <= 1'b1;
            long_cnt_q <= LG_DONE;
         end else if (long_cnt_q != LG_DONE) begin
            long_cnt_q <= long_cnt_q + LG_ONE;
         end
      end
   end

   assign long_pulse = long_q;
`else
   if (LONG_CYCLES == 0) begin : g_long_chk
      $error("LONG_CYCLES must be at least 1");
   end

   assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// Debounced multi-button reader with per-channel pending slots, a lowest-index
// arbiter and an event FIFO. Long-press events exist only with BTN_LONG_PRESS_EN.
module button_reader
   import button_pkg::*;
#(
   parameter int unsigned NUM_BTN         = 6,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned LONG_CYCLES     = 50000000,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_state,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_long,
   output logic               evt_valid,
   output logic [EVT_W-1:0]   evt_data,
   input  logic               evt_ready,
   output logic               evt_overflow,
   input  logic               evt_ovf_clr
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

   if ((NUM_BTN == 0) || (NUM_BTN > 8)) begin : g_num_chk
      $error("NUM_BTN must be in 1..8");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_deb_chk
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .btn_raw     (btn_in[g]),
         .state       (btn_state[g]),
         .press_pulse (btn_press[g]),
         .rel_pulse   (btn_release[g]),
         .long_pulse  (btn_long[g])
      );
   end

   logic [NUM_BTN-1:0] pend_vld_q;
   evt_type_e          pend_type_q [NUM_BTN];
   logic [NUM_BTN-1:0] pulse_any;
   evt_type_e          pulse_type [NUM_BTN];
   logic               arb_hit;
   logic [NUM_BTN-1:0] arb_sel;
   logic [EVT_W-1:0]   arb_data;
   logic [NUM_BTN-1:0] take;
   logic               ovf_set;

   logic [EVT_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW:0]        wr_ptr_q;
   logic [AW:0]        rd_ptr_q;
   logic [AW:0]        fifo_cnt;
   logic               full;
   logic               push;
   logic               pop;

   // Classify each channel's pulse; at most one pulse per channel per cycle
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         pulse_any[i] = btn_press[i] | btn_release[i] | btn_long[i];
         if (btn_long[i]) begin
            pulse_type[i] = EvtLong;
         end else if (btn_release[i]) begin
            pulse_type[i] = EvtRelease;
         end else begin
            pulse_type[i] = EvtPress;
         end
      end
   end

   // Pick the lowest-index pending slot; scanning downward lets the lowest win
   always_comb begin
      arb_hit  = 1'b0;
      arb_sel  = '0;
      arb_data = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pend_vld_q[i]) begin
            arb_hit    = 1'b1;
            arb_sel    = '0;
            arb_sel[i] = 1'b1;
            arb_data   = {pend_type_q[i], CH_W'(i)};
         end
      end
   end

   assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
   assign full      = (fifo_cnt == FULL_CNT);
   assign evt_valid = (fifo_cnt != '0);
   assign pop       = evt_valid && evt_ready;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
   assign push      = arb_hit && (!full || pop);
   assign take      = push ? arb_sel : '0;
   // Only a pulse landing on a slot that is not leaving this cycle loses an event
   assign ovf_set   = |(pulse_any & pend_vld_q & ~take);
   assign evt_data  = evt_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

   // Pending slots: a new pulse overwrites, otherwise the slot empties when pushed
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld_q <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            pend_type_q[i] <= EvtPress;
         end
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (pulse_any[i]) begin
               pend_vld_q[i]  <= 1'b1;
               pend_type_q[i] <= pulse_type[i];
            end else if (take[i]) begin
               pend_vld_q[i] <= 1'b0;
            end
         end
      end
   end

   // Sticky overflow flag; a new overflow beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_overflow <= 1'b0;
      end else if (ovf_set) begin
         evt_overflow <= 1'b1;
      end else if (evt_ovf_clr) begin
         evt_overflow <= 1'b0;
      end
   end

   // FIFO pointers carry one extra wrap bit to tell full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

   // FIFO storage; contents are masked at the output while empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= arb_data;
      end
   end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with an event scoreboard. Long-press steps
// follow the BTN_LONG_PRESS_EN build setting.
module tb_button_reader;
   import button_pkg::*;

   localparam int unsigned NB    = 6;
   localparam int unsigned DEB   = 8;
   localparam int unsigned LONG  = 20;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_in = '0;
   logic [NB-1:0] btn_state, btn_press, btn_release, btn_long;
   logic          evt_valid;
   logic [4:0]    evt_data;
   logic          evt_ready = 1'b0;
   logic          evt_overflow;
   logic          evt_ovf_clr = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [4:0] exp_q [$];
   int pop_cyc [$];
   int n_press [NB];
   int n_rel [NB];
   int n_long [NB];

   button_reader #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LONG),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in),
      .btn_state    (btn_state),
      .btn_press    (btn_press),
      .btn_release  (btn_release),
      .btn_long     (btn_long),
      .evt_valid    (evt_valid),
      .evt_data     (evt_data),
      .evt_ready    (evt_ready),
      .evt_overflow (evt_overflow),
      .evt_ovf_clr  (evt_ovf_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse counters and scoreboard pop, sampled away from the rising edge
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NB; i++) begin
            if (btn_press[i]) n_press[i]++;
            if (btn_release[i]) n_rel[i]++;
            if (btn_long[i]) n_long[i]++;
         end
         if (evt_valid && evt_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL evt_unexpected: observed %0h expected none", evt_data);
            end
            if (exp_q.size() > 0) begin
               chk("evt_data", {27'd0, evt_data}, {27'd0, exp_q.pop_front()});
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      for (int i = 0; i < NB; i++) begin
         n_press[i] = 0;
         n_rel[i] = 0;
         n_long[i] = 0;
      end
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || evt_valid) && n < 300) begin
         step(1);
         n++;
      end
      chk({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      int first;
      int first_vld;
      clr_counts();
      step(3);
      chk("rst_state", {26'd0, btn_state}, 0);
      chk("rst_press", {26'd0, btn_press}, 0);
      chk("rst_release", {26'd0, btn_release}, 0);
      chk("rst_long", {26'd0, btn_long}, 0);
      chk("rst_valid", {31'd0, evt_valid}, 0);
      chk("rst_data", {27'd0, evt_data}, 0);
      chk("rst_ovf", {31'd0, evt_overflow}, 0);
      rst = 1'b0;
      evt_ready = 1'b1;
      step(2);

      // Single press on ch2: pulse latency and event word
      clr_counts();
      btn_in[2] = 1'b1;
      exp_q.push_back(5'b00_010);
      first = -1;
      first_vld = -1;
      for (int i = 1; i <= 14; i++) begin
         step(1);
         if (btn_press[2] && first < 0) first = i;
         if (evt_valid && first_vld < 0) first_vld = i;
      end
      chk("press2_latency", first, 10);
      chk("press2_valid_latency", first_vld, 12);
      chk("press2_state", {31'd0, btn_state[2]}, 1);
      btn_in[2] = 1'b0;
      exp_q.push_back(5'b01_010);
      wait_drain("ch2");
      chk("press2_count", n_press[2], 1);
      chk("release2_count", n_rel[2], 1);

      // 5-cycle glitch on ch0 must vanish
      clr_counts();
      btn_in[0] = 1'b1;
      step(5);
      btn_in[0] = 1'b0;
      step(25);
      chk("glitch_state", {31'd0, btn_state[0]}, 0);
      chk("glitch_press", n_press[0], 0);
      chk("glitch_release", n_rel[0], 0);
      chk("glitch_valid", {31'd0, evt_valid}, 0);

      // Simultaneous press on ch1 and ch4: lowest index first, back to back
      clr_counts();
      pop_cyc.delete();
      btn_in[1] = 1'b1;
      btn_in[4] = 1'b1;
      exp_q.push_back(5'b00_001);
      exp_q.push_back(5'b00_100);
      step(14);
      btn_in[1] = 1'b0;
      btn_in[4] = 1'b0;
      exp_q.push_back(5'b01_001);
      exp_q.push_back(5'b01_100);
      wait_drain("ch1_ch4");
      chk("ch1_ch4_pops", pop_cyc.size(), 4);
      if (pop_cyc.size() >= 2) chk("ch1_ch4_consecutive", pop_cyc[1] - pop_cyc[0], 1);

      // Fill the FIFO with ready low, then overwrite ch3's pending slot
      evt_ready = 1'b0;
      btn_in[0] = 1'b1;
      btn_in[1] = 1'b1;
      exp_q.push_back(5'b00_000);
      exp_q.push_back(5'b00_001);
      step(12);
      btn_in[0] = 1'b0;
      btn_in[1] = 1'b0;
      exp_q.push_back(5'b01_000);
      exp_q.push_back(5'b01_001);
      step(14);
      chk("fill_no_ovf", {31'd0, evt_overflow}, 0);
      btn_in[3] = 1'b1;
      step(12);
      btn_in[3] = 1'b0;
      exp_q.push_back(5'b01_011);
      step(14);
      chk("ovf_set", {31'd0, evt_overflow}, 1);
      chk("full_valid", {31'd0, evt_valid}, 1);
      chk("head_hold_a", {27'd0, evt_data}, 5'b00_000);
      step(3);
      chk("head_hold_b", {27'd0, evt_data}, 5'b00_000);
      evt_ovf_clr = 1'b1;
      step(1);
      evt_ovf_clr = 1'b0;
      chk("ovf_clr", {31'd0, evt_overflow}, 0);
      evt_ready = 1'b1;
      wait_drain("overflow");

`ifdef BTN_LONG_PRESS_EN
      // Long hold on ch5 gives exactly one long pulse and a type-10 event
      clr_counts();
      btn_in[5] = 1'b1;
      exp_q.push_back(5'b00_101);
      exp_q.push_back(5'b10_101);
      step(45);
      chk("long5_count", n_long[5], 1);
      btn_in[5] = 1'b0;
      exp_q.push_back(5'b01_101);
      wait_drain("long5");
      // Short hold produces no long event
      clr_counts();
      btn_in[5] = 1'b1;
      exp_q.push_back(5'b00_101);
      step(14);
      btn_in[5] = 1'b0;
      exp_q.push_back(5'b01_101);
      wait_drain("short5");
      chk("short5_long", n_long[5], 0);
`else
      // Without the long-press build, a long hold yields only press and release
      clr_counts();
      btn_in[5] = 1'b1;
      exp_q.push_back(5'b00_101);
      step(45);
      chk("nolong5_count", n_long[5], 0);
      btn_in[5] = 1'b0;
      exp_q.push_back(5'b01_101);
      wait_drain("nolong5");
`endif

      // Reset with three queued events discards them; held buttons re-press
      evt_ready = 1'b0;
      btn_in[2:0] = 3'b111;
      step(16);
      chk("preq_valid", {31'd0, evt_valid}, 1);
      rst = 1'b1;
      step(1);
      chk("rstq_valid", {31'd0, evt_valid}, 0);
      chk("rstq_data", {27'd0, evt_data}, 0);
      chk("rstq_state", {26'd0, btn_state}, 0);
      rst = 1'b0;
      evt_ready = 1'b1;
      exp_q.push_back(5'b00_000);
      exp_q.push_back(5'b00_001);
      exp_q.push_back(5'b00_010);
      first = -1;
      for (int i = 1; i <= 14; i++) begin
         step(1);
         if (btn_press[0] && first < 0) first = i;
      end
      chk("press_after_rst", first, DEB + 2);
      btn_in[2:0] = 3'b000;
      exp_q.push_back(5'b01_000);
      exp_q.push_back(5'b01_001);
      exp_q.push_back(5'b01_010);
      wait_drain("after_rst");
      step(10);
      chk("end_valid", {31'd0, evt_valid}, 0);
      chk("end_ovf", {31'd0, evt_overflow}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
